rtc_field_editor: RTL and testbench
===================================

RTC_FIELD_EDITOR -- requirements
Module: rtc_field_editor

Interface
REQ-001 Parameter NUM_FIELDS, default 9, meaning number of fields swept (1..9), field indices 1..NUM_FIELDS.
REQ-002 Parameter ADDR_W, default 4, meaning width of the user-register-bank address.
REQ-003 Parameter TIMER_CTL_EN, default 1, meaning whether the timer-control write precedes the sweep.
REQ-004 The port list SHALL be as follows.
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  level; high starts and sustains a sweep.
- int2  in  1  timer-run request.
- fin  in  1  write-done from the bus writer.
- dato, dato_up, dato_down  in  8 each  bank value (BCD), increment flag byte, decrement flag byte at addr.
- addr  out  ADDR_W  bank field index.
- erase  out  1  one-cycle clear of the up/down flags.
- escribe  out  1  write request.
- dir_out  out  8  RTC register address.
- dato_out  out  8  BCD write data.
- final  out  1  one-cycle sweep-complete pulse.
- busy  out  1  high in any state except IDLE.

Function
REQ-005 The FSM SHALL have the states IDLE, TCTL, READ, CALC, WRITE, CLEAR and DONE.
REQ-006 IDLE→TCTL SHALL occur on iniciar=1; with TIMER_CTL_EN=0 the transition SHALL be IDLE→READ with idx=1.
REQ-007 In TCTL: escribe=1, dir_out=0x00, dato_out=0x08 if int2 else 0x00; the FSM SHALL hold until fin=1, then go to READ with idx=1.
REQ-008 In READ, addr=idx and escribe=0; the next cycle SHALL be CALC, which samples dato, dato_up and dato_down (one-cycle bank read latency).
REQ-009 In CALC, an up request is dato_up≠0 and a down request is dato_down≠0; dato_out SHALL be registered as follows.
- Up only: dato==TOP → MIN; units==9 → tens+1, units 0; else units+1.
- Down only: dato==MIN → TOP; units==0 → tens−1, units 9; else units−1.
- Both or neither: dato unchanged.
- Invalid input (any nibble >9, or dato>TOP, or dato<MIN): MIN, regardless of the request.
REQ-010 In WRITE, escribe=1, dir_out=ADDR(idx) and dato_out held stable; the FSM SHALL hold until fin=1.
REQ-011 In CLEAR, erase=1 and addr=idx for exactly one cycle; then, if idx==NUM_FIELDS → DONE, else idx+1 → READ.
REQ-012 DONE SHALL assert final for one cycle, then go to IDLE; a new sweep requires iniciar to be observed high in IDLE again.
REQ-013 Every field SHALL be written each sweep, even when unchanged.
REQ-014 fin arriving in a state other than TCTL or WRITE SHALL be ignored.
REQ-015 iniciar=0 in any state SHALL abort synchronously to IDLE with every output at its reset value, no erase and no final.
REQ-016 escribe SHALL never be asserted in the same cycle as erase or final.

Reset
REQ-017 Asynchronous reset=1 SHALL force state IDLE and idx=1, with every output at its reset value.
REQ-018 Output reset values SHALL be 0 for addr, erase, escribe, dir_out, dato_out, final and busy.
REQ-019 A reset asserted mid-write SHALL drop escribe immediately, not waiting for fin.

Structure
REQ-020 The shared package rtc_edit_pkg SHALL hold the state encoding and the per-field tables below, plus the constants CTL_ADDR=0x00 and CTL_RUN=0x08.
- TOP, index 1..9: 59,59,23,31,12,99,59,59,23.
- MIN: 01 for day and month, else 00.
- ADDR: 0x21–0x26, 0x41–0x43.
REQ-021 The BCD step logic SHALL be a combinational sub-module bcd_step(dato, top, min, up, down → q), instantiated once.

Verification
REQ-022 iniciar=1, int2=1, all flags 0, fin one cycle after each escribe → TCTL write 0x08@0x00, then 9 writes of unchanged data to 0x21..0x43, 9 erase pulses, one final.
REQ-023 Field 1 dato=0x59, dato_up=1 → dato_out=0x00@0x21; field 4 dato=0x01, dato_down=1 → dato_out=0x31@0x24.
REQ-024 Field 2 dato=0x09 up → 0x10; dato=0x10 down → 0x09; dato_up=dato_down=1 → 0x10 unchanged.
REQ-025 Field 5 dato=0x1A → 0x01@0x25; field 3 dato=0x24 → 0x00@0x23.
REQ-026 fin withheld for 20 cycles in WRITE → escribe, dir_out and dato_out stay stable; iniciar dropped at field 5 → IDLE next cycle, no final, no further erase.
REQ-027 With NUM_FIELDS=6 and TIMER_CTL_EN=0 → no 0x00 write, 6 writes, final after field 6; async reset mid-WRITE → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/rtc_edit_pkg.sv
// rtc_edit_pkg: state encoding and per-field limit/address tables for the RTC field editor
package rtc_edit_pkg;

    typedef enum logic [2:0] {IDLE, TCTL, READ, CALC, WRITE, CLEAR, DONE} state_t;

    localparam logic [7:0] CTL_ADDR = 8'h00;
    localparam logic [7:0] CTL_RUN  = 8'h08;

    function automatic logic [7:0] field_top(input logic [3:0] i);
        return (i == 4'd3 || i == 4'd9) ? 8'h23 :
               (i == 4'd4) ? 8'h31 :
               (i == 4'd5) ? 8'h12 :
               (i == 4'd6) ? 8'h99 : 8'h59;
    endfunction

    function automatic logic [7:0] field_min(input logic [3:0] i);
        return (i == 4'd4 || i == 4'd5) ? 8'h01 : 8'h00;
    endfunction

    // fields 1..6 map to 0x21..0x26, fields 7..9 to 0x41..0x43
    function automatic logic [7:0] field_addr(input logic [3:0] i);
        return (i < 4'd7) ? 8'h20 + {4'h0, i} : 8'h3A + {4'h0, i};
    endfunction

endpackage

// File: rtl/rtc_field_editor_if.sv
// rtc_field_editor_if: bank read, RTC write handshake and sweep status bundle
interface rtc_field_editor_if #(parameter int ADDR_W = 4);
    logic              iniciar;
    logic              int2;
    logic              fin;
    logic [7:0]        dato;
    logic [7:0]        dato_up;
    logic [7:0]        dato_down;
    logic [ADDR_W-1:0] addr;
    logic              erase;
    logic              escribe;
    logic [7:0]        dir_out;
    logic [7:0]        dato_out;
    logic              sweep_final;
    logic              busy;

    modport master (
        input  iniciar, int2, fin, dato, dato_up, dato_down,
        output addr, erase, escribe, dir_out, dato_out, sweep_final, busy
    );

    modport slave (
        output iniciar, int2, fin, dato, dato_up, dato_down,
        input  addr, erase, escribe, dir_out, dato_out, sweep_final, busy
    );
endinterface

// File: rtl/rtc_field_editor_bcd_step.sv
// bcd_step: one-step BCD increment/decrement with wraparound and invalid-value recovery to min
module bcd_step (
    input  logic [7:0] dato,
    input  logic [7:0] top,
    input  logic [7:0] min,
    input  logic       up,
    input  logic       down,
    output logic [7:0] q
);
    logic [3:0] t, u;
    logic       bad;

    assign t   = dato[7:4];
    assign u   = dato[3:0];
    assign bad = t > 4'd9 || u > 4'd9 || dato > top || dato < min;
    assign q   = bad ? min :
                 (up && !down) ? (dato == top ? min : u == 4'd9 ? {t + 4'd1, 4'd0} : dato + 8'd1) :
                 (down && !up) ? (dato == min ? top : u == 4'd0 ? {t - 4'd1, 4'd9} : dato - 8'd1) :
                 dato;
endmodule

// File: rtl/rtc_field_editor.sv
// rtc_field_editor: sweeps the user register bank, steps flagged fields in BCD and writes every field to the RTC
module rtc_field_editor
    import rtc_edit_pkg::*;
#(
    parameter int NUM_FIELDS   = 9,
    parameter int ADDR_W       = 4,
    parameter int TIMER_CTL_EN = 1
) (
    input logic clk,
    input logic reset,
    rtc_field_editor_if.master bus
);
    state_t     state, nxt;
    logic [3:0] idx;
    logic [7:0] dq, q;

    bcd_step u_step (
        .dato (bus.dato),
        .top  (field_top(idx)),
        .min  (field_min(idx)),
        .up   (|bus.dato_up),
        .down (|bus.dato_down),
        .q    (q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 4'd1;
            dq    <= 8'h00;
        end else begin
            state <= nxt;
            idx   <= nxt == IDLE ? 4'd1 : (state == CLEAR && nxt == READ) ? idx + 4'd1 : idx;
            dq    <= state == CALC ? q : dq;
        end
    end

    // outputs are decoded from state alone so reset clears them without a clock edge
    always_comb begin
        nxt             = state;
        bus.addr        = '0;
        bus.erase       = 1'b0;
        bus.escribe     = 1'b0;
        bus.dir_out     = 8'h00;
        bus.dato_out    = 8'h00;
        bus.sweep_final = 1'b0;
        bus.busy        = state != IDLE;
        case (state)
            IDLE:  nxt = bus.iniciar ? (TIMER_CTL_EN != 0 ? TCTL : READ) : IDLE;
            TCTL: begin
                bus.escribe  = 1'b1;
                bus.dir_out  = CTL_ADDR;
                bus.dato_out = bus.int2 ? CTL_RUN : 8'h00;
                nxt          = bus.fin ? READ : TCTL;
            end
            READ: begin
                bus.addr = ADDR_W'(idx);
                nxt      = CALC;
            end
            CALC: begin
                bus.addr = ADDR_W'(idx);
                nxt      = WRITE;
            end
            WRITE: begin
                bus.addr     = ADDR_W'(idx);
                bus.escribe  = 1'b1;
                bus.dir_out  = field_addr(idx);
                bus.dato_out = dq;
                nxt          = bus.fin ? CLEAR : WRITE;
            end
            CLEAR: begin
                bus.addr  = ADDR_W'(idx);
                bus.erase = 1'b1;
                nxt       = idx == 4'(NUM_FIELDS) ? DONE : READ;
            end
            DONE: begin
                bus.sweep_final = 1'b1;
                nxt             = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (!bus.iniciar) nxt = IDLE;
    end
endmodule

// File: tb/tb_rtc_field_editor.sv
// tb_rtc_field_editor: directed checks of two editor configurations against a simple bank and write responder
module tb_rtc_field_editor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0;
    logic int2 = 1'b0;
    logic fin = 1'b0;
    logic sel = 1'b0;
    logic hold = 1'b0;
    logic [7:0] bank [0:15];
    logic [7:0] upf [0:15];
    logic [7:0] dnf [0:15];
    logic [7:0] wdir [0:15];
    logic [7:0] wdat [0:15];
    logic [7:0] exp_dir [1:9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] dflt [1:9] = '{8'h30, 8'h15, 8'h10, 8'h20, 8'h06, 8'h24, 8'h00, 8'h45, 8'h12};
    int checks = 0, errors = 0;
    int nw, ne, nf, overlap, cnt;
    logic found, stable;
    logic [7:0] cap;

    always #5 clk = ~clk;

    rtc_field_editor_if #(.ADDR_W(4)) ia ();
    rtc_field_editor_if #(.ADDR_W(4)) ib ();

    rtc_field_editor dut_a (.clk(clk), .reset(reset), .bus(ia));
    rtc_field_editor #(.NUM_FIELDS(6), .ADDR_W(4), .TIMER_CTL_EN(0)) dut_b (.clk(clk), .reset(reset), .bus(ib));

    assign ia.iniciar   = iniciar & ~sel;
    assign ib.iniciar   = iniciar & sel;
    assign ia.fin       = fin & ~sel;
    assign ib.fin       = fin & sel;
    assign ia.int2      = int2;
    assign ib.int2      = int2;
    assign ia.dato      = bank[ia.addr];
    assign ia.dato_up   = upf[ia.addr];
    assign ia.dato_down = dnf[ia.addr];
    assign ib.dato      = bank[ib.addr];
    assign ib.dato_up   = upf[ib.addr];
    assign ib.dato_down = dnf[ib.addr];

    wire       o_esc  = sel ? ib.escribe : ia.escribe;
    wire       o_era  = sel ? ib.erase : ia.erase;
    wire       o_fin  = sel ? ib.sweep_final : ia.sweep_final;
    wire       o_busy = sel ? ib.busy : ia.busy;
    wire [7:0] o_dir  = sel ? ib.dir_out : ia.dir_out;
    wire [7:0] o_dat  = sel ? ib.dato_out : ia.dato_out;
    wire [3:0] o_addr = sel ? ib.addr : ia.addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic defaults();
        for (int i = 0; i < 16; i++) begin
            bank[i] = (i >= 1 && i <= 9) ? dflt[i] : 8'h00;
            upf[i]  = 8'h00;
            dnf[i]  = 8'h00;
        end
    endtask

    task automatic clr();
        nw = 0; ne = 0; nf = 0; overlap = 0; cnt = 0;
    endtask

    // one negedge: log events and answer writes with fin on the second write cycle
    task automatic step();
        @(negedge clk);
        if (o_esc) begin
            if (cnt == 0 && nw < 16) begin
                wdir[nw] = o_dir;
                wdat[nw] = o_dat;
                nw++;
            end
            fin = hold ? 1'b0 : (cnt >= 1);
            cnt++;
        end else begin
            fin = 1'b0;
            cnt = 0;
        end
        if (o_esc && (o_era || o_fin)) overlap++;
        if (o_era) ne++;
        if (o_fin) nf++;
    endtask

    task automatic sweep();
        clr();
        iniciar = 1'b1;
        for (int c = 0; c < 300 && nf == 0; c++) step();
        iniciar = 1'b0;
        fin = 1'b0;
        step();
    endtask

    task automatic zero_outs(input string tag);
        chk({tag, "_esc"}, o_esc, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_dir"}, o_dir, 0);
        chk({tag, "_dat"}, o_dat, 0);
        chk({tag, "_addr"}, o_addr, 0);
        chk({tag, "_erase"}, o_era, 0);
        chk({tag, "_final"}, o_fin, 0);
    endtask

    initial begin
        defaults();
        #1;
        zero_outs("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        int2 = 1'b1;
        sweep();
        chk("s1_nw", nw, 10);
        chk("s1_ctl_dir", wdir[0], 8'h00);
        chk("s1_ctl_dat", wdat[0], 8'h08);
        for (int i = 1; i <= 9; i++) begin
            chk($sformatf("s1_dir%0d", i), wdir[i], exp_dir[i]);
            chk($sformatf("s1_dat%0d", i), wdat[i], dflt[i]);
        end
        chk("s1_erase", ne, 9);
        chk("s1_final", nf, 1);
        chk("s1_overlap", overlap, 0);
        chk("s1_idle", o_busy, 0);

        defaults();
        int2 = 1'b0;
        bank[1] = 8'h59; upf[1] = 8'h01;
        bank[2] = 8'h09; upf[2] = 8'h80;
        bank[3] = 8'h24;
        bank[4] = 8'h01; dnf[4] = 8'h01;
        bank[5] = 8'h1A; upf[5] = 8'h01;
        bank[7] = 8'h3A; dnf[7] = 8'h01;
        sweep();
        chk("s2_nw", nw, 10);
        chk("s2_ctl_dat", wdat[0], 8'h00);
        chk("s2_f1_wrap", wdat[1], 8'h00);
        chk("s2_f1_dir", wdir[1], 8'h21);
        chk("s2_f2_carry", wdat[2], 8'h10);
        chk("s2_f3_over", wdat[3], 8'h00);
        chk("s2_f4_wrap", wdat[4], 8'h31);
        chk("s2_f4_dir", wdir[4], 8'h24);
        chk("s2_f5_bad", wdat[5], 8'h01);
        chk("s2_f5_dir", wdir[5], 8'h25);
        chk("s2_f7_bad", wdat[7], 8'h00);

        defaults();
        bank[2] = 8'h10; dnf[2] = 8'h01;
        bank[4] = 8'h31; upf[4] = 8'h01;
        bank[5] = 8'h12; upf[5] = 8'h01;
        bank[6] = 8'h10; upf[6] = 8'h01; dnf[6] = 8'h01;
        bank[8] = 8'h39; upf[8] = 8'h01;
        bank[9] = 8'h00; dnf[9] = 8'h01;
        sweep();
        chk("s3_f2_borrow", wdat[2], 8'h09);
        chk("s3_f4_wrap", wdat[4], 8'h01);
        chk("s3_f5_wrap", wdat[5], 8'h01);
        chk("s3_f6_both", wdat[6], 8'h10);
        chk("s3_f8_carry", wdat[8], 8'h40);
        chk("s3_f9_wrap", wdat[9], 8'h23);
        chk("s3_final", nf, 1);

        defaults();
        clr();
        int2 = 1'b1;
        iniciar = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            found = o_esc && o_dir == 8'h22;
        end
        chk("s4_found22", found, 1);
        cap = o_dat;
        hold = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            stable &= o_esc && o_dir == 8'h22 && o_dat == cap;
        end
        chk("s4_stable", stable, 1);
        chk("s4_cap", cap, 8'h15);
        hold = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            found = o_esc && o_dir == 8'h25;
        end
        chk("s4_found25", found, 1);
        iniciar = 1'b0;
        step();
        zero_outs("s4_abort");
        repeat (5) step();
        chk("s4_erase", ne, 4);
        chk("s4_nofinal", nf, 0);

        sel = 1'b1;
        defaults();
        sweep();
        chk("s5_nw", nw, 6);
        chk("s5_dir0", wdir[0], 8'h21);
        chk("s5_dir5", wdir[5], 8'h26);
        chk("s5_dat5", wdat[5], 8'h24);
        chk("s5_erase", ne, 6);
        chk("s5_final", nf, 1);
        clr();
        iniciar = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            found = o_esc;
        end
        chk("s5_inwrite", found, 1);
        #2 reset = 1'b1;
        #1;
        zero_outs("s5_async");
        @(negedge clk);
        iniciar = 1'b0;
        fin = 1'b0;
        reset = 1'b0;
        step();
        chk("s5_post_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
